edge_detector_db: RTL
=====================

Name: edge_detector_db

Overview:
- Upstream front-end of the 8-bit counter input path.
- Takes one raw asynchronous input (button or external signal), synchronizes and debounces it, and registers the stable level.
- Produces one-cycle pulses on rising, falling and any edge. These pulses feed the input selector's iFlancosP / iFlancosN / iFlancosX inputs.

Parameters:
- DB_CYCLES, 16, number of consecutive clock edges a changed synchronized level must persist before it is accepted. Legal range is 1 to 2^CNT_W−1.
- CNT_W, 5, width of the debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- iClk  input  1  system clock; all logic on its rising edge.
- iReset  input  1  asynchronous, active-low reset (0 = reset).
- iEntrada  input  1  raw, asynchronous input signal.
- iEnable  input  1  1 = detection active; 0 = hold level, suppress pulses.
- oNivel  output  1  debounced, registered level of iEntrada.
- oFlancosP  output  1  one-cycle pulse on accepted 0→1 transition.
- oFlancosN  output  1  one-cycle pulse on accepted 1→0 transition.
- oFlancosX  output  1  one-cycle pulse on any accepted transition (P | N, registered).

Behaviour:
- Reset (iReset=0, asynchronous): sync FFs, oNivel, all pulse outputs, counter and FSM clear to 0 / ESTABLE immediately. Reset is held as long as iReset=0, including mid-validation.
- Synchronizer:
  - 2-FF chain on iEntrada; s_sync = second FF.
  - Always running, independent of iEnable.
- FSM states:
  - ESTABLE, counter = 0.
    - If iEnable=1 and s_sync≠oNivel: with DB_CYCLES=1, commit immediately; otherwise go to VALIDANDO with counter←1.
  - VALIDANDO:
    - If iEnable=0: go to ESTABLE, counter←0, no commit.
    - Else if s_sync=oNivel: glitch rejected; go to ESTABLE, counter←0.
    - Else if counter=DB_CYCLES−1: commit.
    - Else counter←counter+1.
- Commit (single clock edge):
  - oNivel←s_sync; FSM←ESTABLE; counter←0.
  - oFlancosP←s_sync; oFlancosN←~s_sync; oFlancosX←1.
- Pulses:
  - Registered outputs, high exactly one cycle, coincident with the cycle in which oNivel first shows the new value.
  - Forced to 0 in every non-commit cycle.
  - P and N are never high together.
- Latency: iEntrada change sampled at edge 0 and held → commit at edge DB_CYCLES+1. That is 2 sync edges plus DB_CYCLES edges of agreement, with the first agreeing edge being edge 2.
- Disabled (iEnable=0):
  - oNivel holds; no pulses.
  - On re-enable with s_sync≠oNivel, validation starts fresh; commit occurs on the DB_CYCLES-th enabled edge.
- After reset release with iEntrada=1: a rising-edge pulse is produced DB_CYCLES+1 edges later. This is intended; the counter stage treats it as a real edge.
- Counter width: the counter never exceeds DB_CYCLES−1, so there is no wrap.

Optional Feature:
- Macro: EDGE_DET_GLITCH_COUNT_EN.
- Defined:
  - Adds output ovGlitches [7:0]: count of VALIDANDO→ESTABLE transitions caused by s_sync=oNivel (rejected glitches).
  - Does not count iEnable aborts.
  - Saturates at 255; reset to 0 asynchronously; no other clear.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan (DB_CYCLES=4, CNT_W=5):
- Hold iReset=0 with iEntrada=0, then release; idle 20 cycles → oNivel=0, P/N/X stay 0 throughout.
- iEntrada 0→1 held, sampled at edge 0 → oNivel=1 and oFlancosP=oFlancosX=1 after edge 5, for exactly 1 cycle; oFlancosN=0.
- From oNivel=1, iEntrada 1→0 held → oFlancosN=oFlancosX=1 for 1 cycle after edge 5; oNivel=0; oFlancosP=0.
- Glitch: iEntrada=1 for 3 cycles then 0 → no pulse, oNivel stays 0. With EDGE_DET_GLITCH_COUNT_EN, ovGlitches=1; repeat 300 glitches → ovGlitches=255.
- iEnable=0, iEntrada 0→1, wait 10 cycles → no pulse, oNivel=0. Set iEnable=1 → oFlancosP pulse after the 4th enabled edge.
- Assert iReset=0 mid-validation (counter=2) → all outputs 0 immediately. Release with iEntrada=1 → oFlancosP pulse after edge 5 counted from the first post-release edge.

Source files
------------

// File: rtl/edge_detector_db.sv
// Synchronizes, debounces and edge-detects one raw asynchronous input; emits registered P/N/X pulses.
// Optional rejected-glitch counter (ovGlitches) is built when EDGE_DET_GLITCH_COUNT_EN is defined.
module edge_detector_db #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iEntrada,
    input  logic       iEnable,
    output logic       oNivel,
    output logic       oFlancosP,
    output logic       oFlancosN,
`ifdef EDGE_DET_GLITCH_COUNT_EN
    output logic       oFlancosX,
    output logic [7:0] ovGlitches
`else
    output logic       oFlancosX
`endif
);

    typedef enum logic {
        ESTABLE   = 1'b0,
        VALIDANDO = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, sync2_q;
    logic               nivel_q, nivel_d;
    logic               pos_q, neg_q, any_q;
    logic               commit;
    logic               glitch;
    logic               s_sync;

    assign s_sync = sync2_q;

    // Two-flop synchronizer runs regardless of iEnable.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= iEntrada;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q <= ESTABLE;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nivel_q <= nivel_d;
            pos_q   <= commit & s_sync;
            neg_q   <= commit & ~s_sync;
            any_q   <= commit;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        glitch  = 1'b0;
        case (state_q)
            ESTABLE: begin
                cnt_d = '0;
                if (iEnable && (s_sync != nivel_q)) begin
                    if (DB_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = VALIDANDO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            VALIDANDO: begin
                if (!iEnable) begin
                    state_d = ESTABLE;
                    cnt_d   = '0;
                end else if (s_sync == nivel_q) begin
                    state_d = ESTABLE;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ESTABLE;
                cnt_d   = '0;
            end
        endcase
        // A commit always lands back in ESTABLE with the new level.
        if (commit) begin
            state_d = ESTABLE;
            cnt_d   = '0;
        end
    end

    assign nivel_d = commit ? s_sync : nivel_q;

    assign oNivel    = nivel_q;
    assign oFlancosP = pos_q;
    assign oFlancosN = neg_q;
    assign oFlancosX = any_q;

`ifdef EDGE_DET_GLITCH_COUNT_EN
    logic [7:0] glitches_q;

    // Saturating count of rejected glitches; enable aborts are not counted.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            glitches_q <= 8'd0;
        end else if (glitch && (glitches_q != 8'hFF)) begin
            glitches_q <= glitches_q + 8'd1;
        end
    end

    assign ovGlitches = glitches_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch;
`endif

endmodule
